// File: rtl/vedic_div_16x8.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock. Divide-by-zero and quotient overflow are
// caught at accept time and finish through a single-cycle error state.
module vedic_div_16x8 #(
  parameter int unsigned N = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2*N-1:0]   i_dividend,
  input  logic [N-1:0]     i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [N-1:0]     o_quotient,
  output logic [N-1:0]     o_remainder,
  output logic             o_div_by_zero,
  output logic             o_overflow
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StErr} state_e;

  state_e          r_state;
  state_e          w_state_next;

  // Iteration datapath: partial remainder, dividend-low/quotient shifter, counter.
  logic [N:0]      r_rem;
  logic [N-1:0]    r_q;
  logic [N-1:0]    r_divisor;
  logic [CntW-1:0] r_cnt;
  logic            r_dbz_pend;

  // Registered results.
  logic            r_done;
  logic [N-1:0]    r_quotient;
  logic [N-1:0]    r_remainder;
  logic            r_dbz;
  logic            r_ovf;

  logic [N-1:0]    w_hi;
  logic            w_dbz_in;
  logic            w_ovf_in;
  logic            w_last;
  logic [N:0]      w_shift;
  logic            w_ge;
  logic [N:0]      w_rem_next;
  logic [N-1:0]    w_q_next;

  assign w_hi     = i_dividend[2*N-1:N];
  assign w_dbz_in = (i_divisor == '0);
  // High half >= divisor means the quotient cannot fit in N bits.
  assign w_ovf_in = (w_hi >= i_divisor);
  assign w_last   = (r_cnt == CntW'(N - 1));

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    w_shift    = {r_rem[N-1:0], r_q[N-1]};
    w_ge       = (w_shift >= {1'b0, r_divisor});
    w_rem_next = w_ge ? (w_shift - {1'b0, r_divisor}) : w_shift;
    w_q_next   = {r_q[N-2:0], w_ge};
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = (w_dbz_in || w_ovf_in) ? StErr : StCalc;
        end
      end
      StCalc:  if (w_last) w_state_next = StIdle;
      StErr:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs: busy decoded from state, everything else straight from registers.
  always_comb begin
    o_busy        = (r_state != StIdle);
    o_done        = r_done;
    o_quotient    = r_quotient;
    o_remainder   = r_remainder;
    o_div_by_zero = r_dbz;
    o_overflow    = r_ovf;
  end

  // Datapath and result registers; results only move on the done edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem       <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_dbz_pend  <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_rem      <= {1'b0, w_hi};
            r_q        <= i_dividend[N-1:0];
            r_divisor  <= i_divisor;
            r_cnt      <= '0;
            r_dbz_pend <= w_dbz_in;
          end
        end
        StCalc: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CntW'(1);
          if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next[N-1:0];
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        StErr: begin
          // r_q still holds the untouched low half of the dividend here.
          r_quotient  <= '1;
          r_remainder <= r_dbz_pend ? r_q : '0;
          r_dbz       <= r_dbz_pend;
          r_ovf       <= ~r_dbz_pend;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
